// File: rtl/shift_serializer_ctrl4_pkg.sv
// shift_serializer_ctrl4_pkg: shared state encoding and widths for the serializer controller.
package shift_serializer_ctrl4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int         SR_WIDTH     = 4;
    localparam logic [1:0] BIT_CNT_LAST = 2'd3;

endpackage

// File: rtl/shift_serializer_ctrl4_sr.sv
// shiftregister_left4: 4-bit left shift register with parallel preset and async clear.
module shiftregister_left4
    import shift_serializer_ctrl4_pkg::*;
(
    input  logic                clockpulse,
    input  logic                clear,
    input  logic                serial_input,
    input  logic                preset_enable,
    input  logic [SR_WIDTH-1:0] preset,
    output logic [SR_WIDTH-1:0] signal_q
);

    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear)
            signal_q <= '0;
        else if (preset_enable)
            signal_q <= preset;
        else
            signal_q <= {signal_q[SR_WIDTH-2:0], serial_input};
    end

endmodule

// File: rtl/shift_serializer_ctrl4.sv
// shift_serializer_ctrl4: sequences a shiftregister_left4 as a 4-bit MSB-first serial transmitter.
module shift_serializer_ctrl4
    import shift_serializer_ctrl4_pkg::*;
#(
    parameter logic FILL_BIT   = 1'b0,
    parameter int   GAP_CYCLES = 2
) (
    input  logic                clockpulse,
    input  logic                clear,
    input  logic                start,
    input  logic                abort,
    input  logic [SR_WIDTH-1:0] data_in,
    output logic                serial_out,
    output logic                bit_valid,
    output logic                busy,
    output logic                done,
    output logic [SR_WIDTH-1:0] signal_q
);

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    state_t              state;
    logic [1:0]          bit_cnt;
    logic [3:0]          gap_cnt;
    logic [SR_WIDTH-1:0] word_r;
    logic                preset_enable;

    // An abort in LOAD must suppress the preset so the aborted word never reaches the register.
    assign preset_enable = (state == LOAD) && !abort;
    assign busy          = state != IDLE;
    assign bit_valid     = state == SHIFT;
    assign serial_out    = signal_q[SR_WIDTH-1];

    shiftregister_left4 u_sr (
        .clockpulse    (clockpulse),
        .clear         (clear),
        .serial_input  (FILL_BIT),
        .preset_enable (preset_enable),
        .preset        (word_r),
        .signal_q      (signal_q)
    );

    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            word_r  <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && state != IDLE) begin
                state   <= IDLE;
                bit_cnt <= '0;
                gap_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        word_r <= data_in;
                        state  <= LOAD;
                    end
                    LOAD: begin
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                    SHIFT: begin
                        bit_cnt <= bit_cnt + 2'd1;
                        if (bit_cnt == BIT_CNT_LAST) begin
                            done    <= 1'b1;
                            gap_cnt <= '0;
                            state   <= (GAP_CYCLES > 0) ? GAP : IDLE;
                        end
                    end
                    GAP: if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                endcase
            end
        end
    end

endmodule
